// File: rtl/float_add_arb.sv
// float_add_arb: round-robin sharing of one LAT-deep pipelined adder; req_* handshakes in, registered add_a/add_b out, add_ab back, one-hot rsp_valid/rsp_data out, inflight count
module float_add_arb #(
  parameter int N_REQ = 4,
  parameter int LAT = 3
) (
  input  logic                      MAIN_CLK,
  input  logic                      RST,
  input  logic                      hold,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [32*N_REQ-1:0]       req_a,
  input  logic [32*N_REQ-1:0]       req_b,
  output logic [N_REQ-1:0]          req_ready,
  output logic [31:0]               add_a,
  output logic [31:0]               add_b,
  input  logic [31:0]               add_ab,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [31:0]               rsp_data,
  output logic [$clog2(LAT+1)-1:0]  inflight
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(LAT+1);
  logic [IW-1:0] last, gnt;
  logic found, fire;
  int idx;
  logic [LAT-1:0] tv;
  logic [IW-1:0] tid [LAT];
  always_comb begin
    gnt = '0;
    found = 1'b0;
    idx = 0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last) + i) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt = IW'(idx);
      end
    end
  end
  assign fire = found & ~hold & ~RST;
  assign req_ready = fire ? N_REQ'(1) << gnt : '0;
  always_ff @(posedge MAIN_CLK or posedge RST) begin
    if (RST) begin
      add_a <= '0;
      add_b <= '0;
      last <= IW'(N_REQ-1);
      tv <= '0;
      for (int i = 0; i < LAT; i++) tid[i] <= '0;
      rsp_valid <= '0;
      rsp_data <= '0;
      inflight <= '0;
    end else begin
      if (fire) begin
        add_a <= req_a[32*gnt +: 32];
        add_b <= req_b[32*gnt +: 32];
        last <= gnt;
      end
      tv[0] <= fire;
      tid[0] <= gnt;
      for (int i = 1; i < LAT; i++) begin
        tv[i] <= tv[i-1];
        tid[i] <= tid[i-1];
      end
      rsp_valid <= tv[LAT-1] ? N_REQ'(1) << tid[LAT-1] : '0;
      if (tv[LAT-1]) rsp_data <= add_ab;
      inflight <= inflight + CW'(fire) - CW'(tv[LAT-1]);
    end
  end
endmodule

// File: tb/tb_float_add_arb.sv
// tb_float_add_arb: directed bench for float_add_arb with a 3-negedge-stage behavioural adder
module tb_float_add_arb;
  logic MAIN_CLK = 1'b0;
  logic RST, hold;
  logic [3:0] req_valid, req_ready, rsp_valid;
  logic [127:0] req_a, req_b;
  logic [31:0] add_a, add_b, add_ab, rsp_data, s1, s2;
  logic [1:0] inflight;
  int total = 0, bad = 0;
  logic [31:0] ta [4];
  logic [31:0] tb_ [4];
  logic [31:0] sum [4];

  float_add_arb #(.N_REQ(4), .LAT(3)) dut (
    .MAIN_CLK(MAIN_CLK), .RST(RST), .hold(hold), .req_valid(req_valid),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready), .add_a(add_a),
    .add_b(add_b), .add_ab(add_ab), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .inflight(inflight));

  always #5 MAIN_CLK = ~MAIN_CLK;

  function automatic logic [63:0] f2d(input logic [31:0] x);
    logic [10:0] e;
    e = {3'b0, x[30:23]} + 11'd896;
    return (x[30:23] == 8'd0) ? 64'd0 : {x[31], e, x[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2f(input logic [63:0] d);
    logic [10:0] e;
    e = d[62:52] - 11'd896;
    return (d[62:0] == 63'd0) ? 32'd0 : {d[63], e[7:0], d[51:29]};
  endfunction

  always @(negedge MAIN_CLK) begin
    s1 <= d2f($realtobits($bitstoreal(f2d(add_a)) + $bitstoreal(f2d(add_b))));
    s2 <= s1;
    add_ab <= s2;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic load();
    for (int i = 0; i < 4; i++) begin
      req_a[32*i +: 32] = ta[i];
      req_b[32*i +: 32] = tb_[i];
    end
  endtask

  task automatic tick();
    @(posedge MAIN_CLK);
    #1;
  endtask

  initial begin
    ta = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
    tb_ = '{32'h3F000000, 32'h3F000000, 32'h3F000000, 32'h3F000000};
    sum = '{32'h3FC00000, 32'h40200000, 32'h40600000, 32'h40900000};
    RST = 1'b1;
    hold = 1'b0;
    req_valid = 4'b1111;
    load();
    #1;
    chk("ready_in_reset", {28'd0, req_ready}, 32'd0);
    tick();
    chk("rst_add_a", add_a, 32'd0);
    chk("rst_add_b", add_b, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("rst_inflight", {30'd0, inflight}, 32'd0);
    RST = 1'b0;
    #1;
    for (int c = 0; c < 11; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      chk("cont_ready", {28'd0, req_ready}, (c < 8) ? 32'd1 << (c % 4) : 32'd0);
      tick();
      if (c < 8) chk("cont_add_a", add_a, ta[c % 4]);
      chk("cont_rsp_valid", {28'd0, rsp_valid}, (c >= 3) ? 32'd1 << ((c - 3) % 4) : 32'd0);
      if (c >= 3) chk("cont_rsp_data", rsp_data, sum[(c - 3) % 4]);
    end
    ta[1] = 32'h40400000;
    tb_[1] = 32'hBF800000;
    load();
    req_valid = 4'b0010;
    #1;
    chk("single_ready", {28'd0, req_ready}, 32'h2);
    tick();
    req_valid = 4'b0000;
    chk("single_add_a", add_a, 32'h40400000);
    chk("single_add_b", add_b, 32'hBF800000);
    chk("single_inflight1", {30'd0, inflight}, 32'd1);
    tick();
    chk("single_rsp_early", {28'd0, rsp_valid}, 32'd0);
    tick();
    chk("single_inflight2", {30'd0, inflight}, 32'd1);
    chk("single_rsp_early2", {28'd0, rsp_valid}, 32'd0);
    tick();
    chk("single_rsp_valid", {28'd0, rsp_valid}, 32'h2);
    chk("single_rsp_data", rsp_data, 32'h40000000);
    chk("single_inflight0", {30'd0, inflight}, 32'd0);
    tick();
    chk("single_rsp_off", {28'd0, rsp_valid}, 32'd0);
    chk("single_data_hold", rsp_data, 32'h40000000);
    ta[1] = 32'h40000000;
    tb_[1] = 32'h3F000000;
    load();
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'b0100 : 4'b0000;
      #1;
      chk("strm_ready", {28'd0, req_ready}, (c < 6) ? 32'h4 : 32'd0);
      tick();
      chk("strm_inflight", {30'd0, inflight}, (c <= 5) ? ((c < 2) ? c + 1 : 3) : 8 - c);
      chk("strm_rsp_valid", {28'd0, rsp_valid}, (c >= 3) ? 32'h4 : 32'd0);
      if (c >= 3) chk("strm_rsp_data", rsp_data, 32'h40600000);
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      hold = (c >= 3);
      #1;
      chk("hold_ready", {28'd0, req_ready}, (c < 3) ? 32'd1 << ((3 + c) % 4) : 32'd0);
      tick();
      chk("hold_inflight", {30'd0, inflight}, (c < 3) ? c + 1 : ((c < 5) ? 5 - c : 0));
      chk("hold_rsp_valid", {28'd0, rsp_valid}, (c >= 3 && c <= 5) ? 32'd1 << (c % 4) : 32'd0);
      if (c >= 3 && c <= 5) chk("hold_rsp_data", rsp_data, sum[c % 4]);
    end
    hold = 1'b0;
    req_valid = 4'b0110;
    tick();
    tick();
    req_valid = 4'b0000;
    chk("mid_inflight", {30'd0, inflight}, 32'd2);
    tick();
    RST = 1'b1;
    #1;
    chk("mid_rsp_valid", {28'd0, rsp_valid}, 32'd0);
    chk("mid_inflight0", {30'd0, inflight}, 32'd0);
    chk("mid_add_a", add_a, 32'd0);
    chk("mid_rsp_data", rsp_data, 32'd0);
    tick();
    RST = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("post_rst_rsp", {28'd0, rsp_valid}, 32'd0);
      chk("post_rst_inflight", {30'd0, inflight}, 32'd0);
    end
    req_valid = 4'b1001;
    #1;
    chk("post_rst_grant", {28'd0, req_ready}, 32'h1);
    tick();
    chk("post_rst_add_a", add_a, 32'h3F800000);
    req_valid = 4'b0000;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
